// File: rtl/issue_if.sv
// ---------------------------------------------------------------------------
// issue_if
// Handshake and bus bundle around issue_ctrl.
//   id_*        : decoded instruction from id_stage (valid/ready)
//   ra/rb/rd_*  : operand and destination enables and register indices
//   ex_*        : issued instruction towards execute (valid/ready)
//   wb_*        : writeback completion, one per cycle at most
//   flush       : discard the buffered, unissued instruction
// Modports:
//   slave  : issue_ctrl side
//   master : surrounding pipeline / testbench side
// ---------------------------------------------------------------------------
interface issue_if;
    logic       id_valid;
    logic       id_ready;
    logic       ra_en;
    logic       rb_en;
    logic       rd_en;
    logic [4:0] ra_addr;
    logic [4:0] rb_addr;
    logic [4:0] rd_addr;
    logic       ex_valid;
    logic       ex_ready;
    logic       ex_rd_en;
    logic [4:0] ex_rd_addr;
    logic       wb_valid;
    logic       wb_rd_en;
    logic [4:0] wb_rd_addr;
    logic       flush;

    modport slave (
        input  id_valid, ra_en, rb_en, rd_en, ra_addr, rb_addr, rd_addr,
        input  ex_ready, wb_valid, wb_rd_en, wb_rd_addr, flush,
        output id_ready, ex_valid, ex_rd_en, ex_rd_addr
    );

    modport master (
        output id_valid, ra_en, rb_en, rd_en, ra_addr, rb_addr, rd_addr,
        output ex_ready, wb_valid, wb_rd_en, wb_rd_addr, flush,
        input  id_ready, ex_valid, ex_rd_en, ex_rd_addr
    );
endinterface

// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
// In-order issue controller: single-entry instruction buffer, 32-entry busy
// scoreboard for pending register writes, and an outstanding-instruction
// window of MAX_OUT (1..15). Stalls on RAW, WAW and a full window.
//
// Ports:
//   clock     : single clock, rising edge
//   reset     : synchronous, active-low
//   bus       : issue_if.slave (id, ex, wb handshakes and flush)
//   busy      : scoreboard, bit i = write to xi pending
//   out_cnt   : instructions issued but not yet written back
//   stall_cnt : hazard-stall cycle counter (only with ISSUE_STALL_CNT_EN)
//
// Optional feature macro: ISSUE_STALL_CNT_EN
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no instruction buffered, ready to accept
// ST_FULL  | one decoded instruction waiting to issue
// ---------------------------------------------------------------------------
module issue_ctrl #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        clock,
    input  logic        reset,
    issue_if.slave      bus,
    output logic [31:0] busy,
    output logic [3:0]  out_cnt
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    state_t      state_q, state_d;

    logic        ra_en_q, rb_en_q, rd_en_q;
    logic [4:0]  ra_addr_q, rb_addr_q, rd_addr_q;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  out_cnt_q, out_cnt_d;

    logic [31:0] wb_mask;
    logic [31:0] busy_eff;
    logic [31:0] set_mask;
    logic        raw_a, raw_b, waw, win_full, hazard;
    logic        ex_valid_c, id_ready_c, issue, accept;

    // A completing write frees its register in the same cycle so that a
    // dependent instruction can issue without a bubble.
    assign wb_mask  = (bus.wb_valid && bus.wb_rd_en) ? (32'd1 << bus.wb_rd_addr) : 32'd0;
    assign busy_eff = busy_q & ~wb_mask;

    assign raw_a    = ra_en_q && (ra_addr_q != 5'd0) && busy_eff[ra_addr_q];
    assign raw_b    = rb_en_q && (rb_addr_q != 5'd0) && busy_eff[rb_addr_q];
    assign waw      = rd_en_q && (rd_addr_q != 5'd0) && busy_eff[rd_addr_q];
    // Any completion frees a slot this cycle, so a full window only blocks
    // when nothing is writing back.
    assign win_full = (out_cnt_q == MAX_OUT_C) && !bus.wb_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hazard     = 1'b0;
        ex_valid_c = 1'b0;
        id_ready_c = 1'b0;
        issue      = 1'b0;
        accept     = 1'b0;

        if (state_q == ST_FULL) begin
            hazard = raw_a || raw_b || waw || win_full;
        end
        ex_valid_c = (state_q == ST_FULL) && !hazard && !bus.flush;
        issue      = ex_valid_c && bus.ex_ready;
        id_ready_c = ((state_q == ST_EMPTY) || issue) && !bus.flush;
        accept     = bus.id_valid && id_ready_c;

        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = ST_FULL;
        end else if (issue) begin
            state_d = ST_EMPTY;
        end
    end

    assign bus.ex_valid   = ex_valid_c;
    assign bus.id_ready   = id_ready_c;
    assign bus.ex_rd_en   = rd_en_q;
    assign bus.ex_rd_addr = rd_addr_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ra_en_q   <= 1'b0;
            rb_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            ra_addr_q <= 5'd0;
            rb_addr_q <= 5'd0;
            rd_addr_q <= 5'd0;
        end else if (accept) begin
            ra_en_q   <= bus.ra_en;
            rb_en_q   <= bus.rb_en;
            rd_en_q   <= bus.rd_en;
            ra_addr_q <= bus.ra_addr;
            rb_addr_q <= bus.rb_addr;
            rd_addr_q <= bus.rd_addr;
        end
    end

    // Set is applied after the writeback clear, so an issue and a
    // completion to the same register leave the bit set.
    always_comb begin
        set_mask = 32'd0;
        if (issue && rd_en_q && (rd_addr_q != 5'd0)) begin
            set_mask = 32'd1 << rd_addr_q;
        end
        busy_d    = (busy_eff | set_mask) & ~32'd1;

        out_cnt_d = out_cnt_q;
        if (issue && !bus.wb_valid) begin
            out_cnt_d = out_cnt_q + 4'd1;
        end else if (!issue && bus.wb_valid && (out_cnt_q != 4'd0)) begin
            out_cnt_d = out_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_q    <= 32'd0;
            out_cnt_q <= 4'd0;
        end else begin
            busy_q    <= busy_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign busy    = busy_q;
    assign out_cnt = out_cnt_q;

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Only hazard stalls count; back-pressure from execute does not.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q == ST_FULL) && hazard && !bus.flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_issue_ctrl
// Directed stimulus for issue_ctrl (MAX_OUT = 4). Each instruction expected to
// issue is pushed into a scoreboard queue when it is driven; a negedge monitor
// pops and compares the destination on every ex handshake. Scoreboard, stall,
// window and flush state are checked against hand-computed values.
// ---------------------------------------------------------------------------
module tb_issue_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] busy;
    logic [3:0]  out_cnt;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    issue_if bus ();

    issue_ctrl #(.MAX_OUT(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus.slave),
        .busy     (busy),
        .out_cnt  (out_cnt)
`ifdef ISSUE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [5:0] e;
        if (reset && bus.ex_valid && bus.ex_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL issue_unexpected: got rd_en=%0b rd=%0d expected no issue at %0t",
                         bus.ex_rd_en, bus.ex_rd_addr, $time);
            end else begin
                e = exp_q.pop_front();
                check("issue_rd", 32'({bus.ex_rd_en, bus.ex_rd_addr}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic ae, input logic [4:0] a,
                            input logic be, input logic [4:0] b,
                            input logic de, input logic [4:0] d);
        bus.id_valid = v;
        bus.ra_en    = ae;
        bus.ra_addr  = a;
        bus.rb_en    = be;
        bus.rb_addr  = b;
        bus.rd_en    = de;
        bus.rd_addr  = d;
    endtask

    task automatic drive_wb(input logic v, input logic en, input logic [4:0] a);
        bus.wb_valid   = v;
        bus.wb_rd_en   = en;
        bus.wb_rd_addr = a;
    endtask

    initial begin
        logic [4:0] win_rd[5];
        logic [4:0] drain_rd[4];
        win_rd   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
        drain_rd = '{5'd2, 5'd3, 5'd4, 5'd6};

        reset = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0);
        drive_wb(0, 0, 0);
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_id_ready", 32'(bus.id_ready), 32'd1);
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_ex_rd_en", 32'(bus.ex_rd_en), 32'd0);
        check("rst_ex_rd_addr", 32'(bus.ex_rd_addr), 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
`ifdef ISSUE_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

        // First instruction rd=5 issues one cycle after accept.
        tick();
        drive_id(1, 0, 0, 0, 0, 1, 5);
        exp_q.push_back({1'b1, 5'd5});
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("first_ex_valid", 32'(bus.ex_valid), 32'd1);
        tick();
        check("first_busy", busy, 32'h20);
        check("first_out_cnt", 32'(out_cnt), 32'd1);
        check("first_ex_valid_after", 32'(bus.ex_valid), 32'd0);

        // RAW on x5: three stall cycles, released by same-cycle writeback.
        drive_id(1, 1, 5, 0, 0, 0, 0);
        exp_q.push_back({1'b0, 5'd0});
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("raw_stall_c1", 32'(bus.ex_valid), 32'd0);
        check("raw_stall_id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        check("raw_stall_c2", 32'(bus.ex_valid), 32'd0);
        tick();
        check("raw_stall_c3", 32'(bus.ex_valid), 32'd0);
        tick();
        drive_wb(1, 1, 5);
        #1;
        check("raw_release_same_cycle", 32'(bus.ex_valid), 32'd1);
        tick();
        drive_wb(0, 0, 0);
        #1;
        check("raw_busy_cleared", busy, 32'd0);
        check("raw_out_cnt", 32'(out_cnt), 32'd1);
`ifdef ISSUE_STALL_CNT_EN
        check("stall_cnt_raw", stall_cnt, 32'd3);
`endif

        // Back-pressure from execute is not a hazard stall.
        drive_id(1, 0, 0, 0, 0, 1, 7);
        exp_q.push_back({1'b1, 5'd7});
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        bus.ex_ready = 1'b0;
        #1;
        check("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
        tick();
        tick();
        bus.ex_ready = 1'b1;
        tick();
        check("bp_busy", busy, 32'h80);
        check("bp_out_cnt", 32'(out_cnt), 32'd2);
`ifdef ISSUE_STALL_CNT_EN
        check("stall_cnt_bp", stall_cnt, 32'd3);
`endif
        drive_wb(1, 0, 0);
        tick();
        drive_wb(1, 1, 7);
        tick();
        drive_wb(0, 0, 0);
        #1;
        check("drain1_out_cnt", 32'(out_cnt), 32'd0);
        check("drain1_busy", busy, 32'd0);

        // x0 destination never marks busy; an x0 read never stalls.
        drive_id(1, 0, 0, 0, 0, 1, 0);
        exp_q.push_back({1'b1, 5'd0});
        tick();
        drive_id(1, 1, 0, 1, 0, 0, 0);
        exp_q.push_back({1'b0, 5'd0});
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("x0_busy", busy, 32'd0);
        check("x0_read_ex_valid", 32'(bus.ex_valid), 32'd1);
        tick();
        check("x0_out_cnt", 32'(out_cnt), 32'd2);
        drive_wb(1, 1, 0);
        tick();
        tick();
        drive_wb(0, 0, 0);
        #1;
        check("drain2_out_cnt", 32'(out_cnt), 32'd0);

        // WAW on x3; issue and writeback of x3 in one cycle leaves it busy.
        drive_id(1, 0, 0, 0, 0, 1, 3);
        exp_q.push_back({1'b1, 5'd3});
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive_id(1, 0, 0, 0, 0, 1, 3);
        exp_q.push_back({1'b1, 5'd3});
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("waw_stall", 32'(bus.ex_valid), 32'd0);
        tick();
        drive_wb(1, 1, 3);
        #1;
        check("waw_release", 32'(bus.ex_valid), 32'd1);
        tick();
        drive_wb(0, 0, 0);
        #1;
        check("waw_set_wins_busy", busy, 32'h08);
        check("waw_out_cnt", 32'(out_cnt), 32'd1);
        drive_wb(1, 1, 3);
        tick();
        drive_wb(0, 0, 0);
        #1;
        check("drain3_busy", busy, 32'd0);
        check("drain3_out_cnt", 32'(out_cnt), 32'd0);

        // Window: back-to-back issue of four, fifth stalls at out_cnt=4.
        for (int i = 0; i < 5; i++) begin
            drive_id(1, 0, 0, 0, 0, 1, win_rd[i]);
            exp_q.push_back({1'b1, win_rd[i]});
            #1;
            check("win_id_ready", 32'(bus.id_ready), 32'd1);
            if (i > 0) check("win_b2b_ex_valid", 32'(bus.ex_valid), 32'd1);
            tick();
        end
        drive_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("win_full_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("win_full_out_cnt", 32'(out_cnt), 32'd4);
        tick();
        check("win_full_hold", 32'(bus.ex_valid), 32'd0);
        drive_wb(1, 1, 1);
        #1;
        check("win_release_same_cycle", 32'(bus.ex_valid), 32'd1);
        tick();
        drive_wb(0, 0, 0);
        #1;
        check("win_out_cnt_stays", 32'(out_cnt), 32'd4);
        check("win_busy", busy, 32'h5C);

        // Flush a stalled buffer while a new instruction is offered.
        drive_id(1, 0, 0, 0, 0, 1, 8);
        tick();
        drive_id(1, 0, 0, 0, 0, 1, 9);
        bus.flush = 1'b1;
        #1;
        check("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("flush_id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("flush_empty_id_ready", 32'(bus.id_ready), 32'd1);
        check("flush_empty_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("flush_busy_kept", busy, 32'h5C);
        check("flush_out_cnt_kept", 32'(out_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive_wb(1, 1, drain_rd[i]);
            #1;
            check("flush_no_issue", 32'(bus.ex_valid), 32'd0);
            tick();
        end
        drive_wb(0, 0, 0);
        #1;
        check("drain4_busy", busy, 32'd0);
        check("drain4_out_cnt", 32'(out_cnt), 32'd0);

        // Reset mid-operation, then a spurious completion saturates at 0.
        drive_id(1, 0, 0, 0, 0, 1, 10);
        exp_q.push_back({1'b1, 5'd10});
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("pre_rst_busy", busy, 32'h400);
        check("pre_rst_out_cnt", 32'(out_cnt), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 32'd0);
        check("midrst_out_cnt", 32'(out_cnt), 32'd0);
        check("midrst_id_ready", 32'(bus.id_ready), 32'd1);
        check("midrst_ex_rd_en", 32'(bus.ex_rd_en), 32'd0);
`ifdef ISSUE_STALL_CNT_EN
        check("midrst_stall_cnt", stall_cnt, 32'd0);
`endif
        drive_wb(1, 1, 10);
        tick();
        drive_wb(0, 0, 0);
        #1;
        check("spurious_wb_out_cnt", 32'(out_cnt), 32'd0);
        check("spurious_wb_busy", busy, 32'd0);

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

In-order issue controller between `id_stage` and the execute/writeback path. It holds one decoded instruction in a single-entry buffer and tracks register writes that are still pending with a 32-entry busy scoreboard. It stalls on RAW and WAW hazards and on a full outstanding window, and sends the instruction to execute through a valid/ready handshake. Writeback completions clear scoreboard entries and free outstanding slots.

## Interface
Parameters:
- `MAX_OUT`, default 4: maximum instructions issued but not yet written back (1..15).

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `id_valid` in 1: decoded instruction present.
- `id_ready` out 1: issue_ctrl accepts the instruction this cycle.
- `ra_en`, `rb_en`, `rd_en` in 1 each: operand and destination enables from decode.
- `ra_addr`, `rb_addr`, `rd_addr` in 5 each: register indices.
- `ex_valid` out 1: buffered instruction is issuable.
- `ex_ready` in 1: execute accepts.
- `ex_rd_en` out 1: destination enable of the issued instruction.
- `ex_rd_addr` out 5: destination index of the issued instruction.
- `wb_valid` in 1: one instruction completes this cycle.
- `wb_rd_en` in 1: the completing instruction wrote a register.
- `wb_rd_addr` in 5: register written by the completing instruction.
- `flush` in 1: discard the buffered, unissued instruction.
- `busy` out 32: scoreboard, bit i = write to xi pending.
- `out_cnt` out 4: outstanding count.
- `stall_cnt` out 32: hazard-stall cycle counter; present only with `ISSUE_STALL_CNT_EN`.

## Operation
- Buffer FSM has two states:
  - EMPTY -> FULL on accept (`id_valid & id_ready`).
  - FULL -> EMPTY on issue (`ex_valid & ex_ready`) with no new accept.
  - FULL -> FULL on issue plus accept in the same cycle (back-to-back).
  - Any state -> EMPTY on `flush`.
- `id_ready` = state EMPTY | issue this cycle. It is forced 0 while `flush`=1.
- Effective busy is `busy & ~wb_mask`, where `wb_mask` is the one-hot of `wb_rd_addr`, gated by `wb_valid & wb_rd_en`. A completion therefore unblocks a dependent instruction in the same cycle.
- Hazard is asserted (FULL only) on any of:
  - RAW: `ra_en` and effective busy[ra]; likewise `rb_en` and effective busy[rb].
  - WAW: `rd_en` and effective busy[rd].
  - Window full: `out_cnt` == `MAX_OUT` and no `wb_valid` this cycle.
- Index 0 is never busy and never causes a hazard.
- `ex_valid` = FULL & ~hazard & ~flush. `ex_rd_en` and `ex_rd_addr` are driven from the buffer.
- On issue: set busy[rd] if `rd_en` and rd≠0. If the same index is cleared by writeback in that cycle, the set wins.
- `out_cnt` update:
  - +1 on issue, −1 on `wb_valid`; unchanged when both occur.
  - Saturates at 0: `wb_valid` with `out_cnt`=0 leaves it 0. Busy clear still applies.
  - Never exceeds `MAX_OUT`.
- `flush` does not touch busy or `out_cnt`. In-flight instructions still complete and clear their bits.
- `flush` together with `id_valid`: the new instruction is not accepted.

## Timing
- Reset values: state EMPTY, `id_ready`=1, `ex_valid`=0, `ex_rd_en`=0, `ex_rd_addr`=0, `busy`=0, `out_cnt`=0, `stall_cnt`=0.
- Reset mid-operation discards the buffer and all scoreboard state on the next edge; completions of pre-reset instructions are then treated as spurious.
- Accept at edge N means `ex_valid` can be asserted in cycle N+1 (minimum issue latency 1).
- With no hazards and `ex_ready`=1, throughput is 1 instruction per cycle.
- `ex_valid` and `id_ready` are combinational from registered state plus `wb_*`, `ex_ready`, `flush`.
- `ex_valid` may deassert without issuing, e.g. on `flush`.
- Once issued, the instruction is gone; there is no replay.
- Busy and `out_cnt` changes are visible from the cycle after their edge. The exception is the same-cycle writeback clear described under Operation.

## Configuration
- `ISSUE_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It increments (wrapping at 2^32) on every cycle with FULL & hazard & ~flush.
  - Cycles where `ex_ready`=0 are not counted.
- `ISSUE_STALL_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with `reset`=0 for 2 cycles, then release:
  - all outputs at reset values and `id_ready`=1;
  - `id_valid` with rd=5 issues the next cycle, then busy=0x20 and `out_cnt`=1.
- RAW stall: issue rd=5, then ra=5 with `ra_en`=1:
  - `ex_valid` stays 0 until `wb_valid`, `wb_rd_en`, wb_rd=5;
  - `ex_valid`=1 in that same cycle, and busy[5]=0 after the edge.
- x0 write: rd=0 with `rd_en`=1 issues and busy stays 0. A following ra=0 issues with no stall.
- Window: `MAX_OUT`=4, 5 independent instructions, no writeback:
  - 4 issue and the 5th stalls with `out_cnt`=4;
  - a single `wb_valid` releases it in the same cycle and `out_cnt` stays 4.
- Flush: buffer FULL and stalled, assert `flush` together with `id_valid`:
  - `ex_valid`=0, state EMPTY next cycle, new instruction not accepted;
  - busy and `out_cnt` unchanged.
- Counter (macro on): 3-cycle RAW stall then issue gives `stall_cnt`=3. With `ex_ready`=0 for 2 additional cycles and no hazard, `stall_cnt` stays 3.
